// File: rtl/i2c_touch_target_pkg.sv
// i2c_touch_target_pkg: shared FSM state enum, default target address and ACK/NACK line levels
package i2c_touch_target_pkg;
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK} state_t;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h38;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_touch_target_if.sv
// i2c_touch_target_if: I2C pins (scl_in, sda_in, sda_oe), Avalon-MM port (address, chipselect, write_n, writedata, readdata) and i2c_wr_irq
interface i2c_touch_target_if #(parameter int PW = 3);
  logic scl_in, sda_in, sda_oe;
  logic [PW-1:0] address;
  logic chipselect, write_n;
  logic [7:0] writedata, readdata;
  logic i2c_wr_irq;
  modport master (output scl_in, sda_in, address, chipselect, write_n, writedata, input sda_oe, readdata, i2c_wr_irq);
  modport slave (input scl_in, sda_in, address, chipselect, write_n, writedata, output sda_oe, readdata, i2c_wr_irq);
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer plus edge detect; d in, level/rise/fall out, strobes held off until the pipeline has settled after reset
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync, warm;
  logic prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= 2'b11;
      prev <= 1'b1;
      warm <= 2'd0;
    end else begin
      sync <= {sync[0], d};
      prev <= sync[1];
      warm <= (&warm) ? warm : warm + 2'd1;
    end
  assign level = sync[1];
  assign rise = (&warm) & sync[1] & ~prev;
  assign fall = (&warm) & ~sync[1] & prev;
endmodule

// File: rtl/i2c_touch_target.sv
// i2c_touch_target: I2C target with byte register file shared with an Avalon-MM host; clk, reset_n (async low), bus (slave modport)
module i2c_touch_target
  import i2c_touch_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int NUM_REGS = 8
) (
  input logic clk,
  input logic reset_n,
  i2c_touch_target_if.slave bus
);
  localparam int PW = $clog2(NUM_REGS);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, ack_on, rw;
  logic [3:0] cnt;
  logic [7:0] sh, rx;
  logic [PW-1:0] ptr;
  logic [7:0] regs [NUM_REGS];
  state_t state;
  i2c_line_sync u_scl (.clk(clk), .reset_n(reset_n), .d(bus.scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda (.clk(clk), .reset_n(reset_n), .d(bus.sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));
  assign start_c = scl_lvl & sda_fall;
  assign stop_c = scl_lvl & sda_rise;
  assign rx = {sh[6:0], sda_lvl};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      ack_on <= 1'b0;
      rw <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.readdata <= '0;
      bus.i2c_wr_irq <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      bus.i2c_wr_irq <= 1'b0;
      if (stop_c) begin
        state <= IDLE;
        bus.sda_oe <= 1'b0;
      end else if (start_c) begin
        state <= ADDR;
        cnt <= '0;
        bus.sda_oe <= 1'b0;
      end else case (state)
        ADDR, PTR, WDATA: if (scl_rise) begin
          sh <= rx;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt <= '0;
            ack_on <= 1'b0;
            if (state == ADDR) begin
              state <= (sh[6:0] == DEV_ADDR) ? ADDR_ACK : IDLE;
              rw <= sda_lvl;
            end else if (state == PTR) begin
              ptr <= rx[PW-1:0];
              state <= PTR_ACK;
            end else begin
              regs[ptr] <= rx;
              bus.i2c_wr_irq <= 1'b1;
              ptr <= ptr + 1'b1;
              state <= WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          ack_on <= !ack_on;
          bus.sda_oe <= !ack_on;
          if (ack_on) begin
            cnt <= '0;
            state <= (state == ADDR_ACK) ? (rw ? RDATA : PTR) : WDATA;
            if (state == ADDR_ACK && rw) begin
              sh <= regs[ptr];
              bus.sda_oe <= ~regs[ptr][7];
              cnt <= 4'd1;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt == 4'd8) begin
            bus.sda_oe <= 1'b0;
            ptr <= ptr + 1'b1;
            state <= RACK;
          end else begin
            bus.sda_oe <= (cnt == 4'd0) ? ~sh[7] : ~sh[6];
            if (cnt != 4'd0) sh <= {sh[6:0], 1'b0};
            cnt <= cnt + 4'd1;
          end
        end
        RACK: if (scl_rise) begin
          state <= (sda_lvl == NACK) ? IDLE : RDATA;
          sh <= regs[ptr];
          cnt <= '0;
        end
        default: ;
      endcase
      if (bus.chipselect && !bus.write_n) regs[bus.address] <= bus.writedata;
      if (bus.chipselect && bus.write_n) bus.readdata <= regs[bus.address];
    end
endmodule
